// File: rtl/mem_llsc_unit_pkg.sv
// Shared definitions for the MEM-stage LL/SC unit:
// FSM state encodings, LL/SC op codes and the reset/write-enable levels.
package mem_llsc_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LL_REQ = 3'd1,
        ST_SC_REQ = 3'd2,
        ST_DONE   = 3'd3,
        ST_ABORT  = 3'd4
    } llsc_state_e;

    localparam logic OP_LL = 1'b0;
    localparam logic OP_SC = 1'b1;

    localparam logic RstEnable   = 1'b1;
    localparam logic WriteEnable = 1'b1;

endpackage

// File: rtl/mem_llsc_unit_link_reg.sv
// Link register: holds the reservation valid flag and linked word address.
// Ports: clk/rst, i_set + i_set_addr, i_clear, i_snoop, i_flush -> o_link_valid/o_link_addr.
module llsc_link_reg
    import mem_llsc_unit_pkg::*;
#(
    parameter int AW = 30
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_set,
    input  logic [AW-1:0] i_set_addr,
    input  logic          i_clear,
    input  logic          i_snoop,
    input  logic          i_flush,
    output logic          o_link_valid,
    output logic [AW-1:0] o_link_addr
);

    logic          r_valid;
    logic [AW-1:0] r_addr;

    // Priority: reset > flush > snoop > clear > set
    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_snoop) begin
            r_valid <= 1'b0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_set) begin
            r_valid <= 1'b1;
            r_addr  <= i_set_addr;
        end
    end

    assign o_link_valid = r_valid;
    assign o_link_addr  = r_addr;

endmodule

// File: rtl/mem_llsc_unit.sv
// MEM-stage LL/SC unit: runs LL loads / SC stores over a req/ack bus,
// tracks the reservation and drives the LLbit write port toward WB.
// Ports: pipeline op in, LLbit + WB bypass in, snoop in, data bus, stall/result/LLbit out.
module mem_llsc_unit
    import mem_llsc_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              op_valid,
    input  logic              op_is_sc,
    input  logic [ADDR_W-1:0] op_addr,
    input  logic [DATA_W-1:0] op_wdata,
    input  logic              llbit_i,
    input  logic              wb_llbit_we_i,
    input  logic              wb_llbit_value_i,
    input  logic              snoop_we,
    input  logic [ADDR_W-1:0] snoop_addr,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              stall_req,
    output logic              result_valid,
    output logic [DATA_W-1:0] result_data,
    output logic              llbit_we_o,
    output logic              llbit_o
);

    localparam int WAW = ADDR_W - 2;

    llsc_state_e r_state, w_next;

    logic [WAW-1:0]    r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_is_sc;
    logic [DATA_W-1:0] r_result;
    logic              r_done_llbit;

    logic           w_link_valid;
    logic [WAW-1:0] w_link_addr;
    logic           w_eff_llbit;
    logic           w_sc_ok;
    logic           w_snoop_link;
    logic           w_snoop_ack;
    logic           w_accept;
    logic           w_capture;
    logic           w_link_set;
    logic           w_link_clr;
    logic           w_unused_lsbs;

    // Byte offsets are always zero for word accesses
    assign w_unused_lsbs = ^{op_addr[1:0], snoop_addr[1:0]};

    assign w_eff_llbit = wb_llbit_we_i ? wb_llbit_value_i : llbit_i;

    assign w_sc_ok = w_eff_llbit & w_link_valid
                   & (op_addr[ADDR_W-1:2] == w_link_addr);

    assign w_snoop_link = snoop_we & w_link_valid
                        & (snoop_addr[ADDR_W-1:2] == w_link_addr);

    // A store to the word whose LL completes this cycle beats the new link
    assign w_snoop_ack = snoop_we & bus_ack & (r_state == ST_LL_REQ)
                       & (snoop_addr[ADDR_W-1:2] == r_addr);

    llsc_link_reg #(.AW(WAW)) u_link (
        .clk          (clk),
        .rst          (rst),
        .i_set        (w_link_set),
        .i_set_addr   (r_addr),
        .i_clear      (w_link_clr),
        .i_snoop      (w_snoop_link | w_snoop_ack),
        .i_flush      (flush),
        .o_link_valid (w_link_valid),
        .o_link_addr  (w_link_addr)
    );

    always_ff @(posedge clk) begin
        if (rst == RstEnable) r_state <= ST_IDLE;
        else                  r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        bus_req      = 1'b0;
        stall_req    = 1'b0;
        result_valid = 1'b0;
        result_data  = '0;
        llbit_we_o   = 1'b0;
        llbit_o      = 1'b0;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_link_set   = 1'b0;
        w_link_clr   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (op_valid && !flush) begin
                    if (op_is_sc == OP_LL) begin
                        w_next    = ST_LL_REQ;
                        w_accept  = 1'b1;
                        stall_req = 1'b1;
                    end else if (w_sc_ok) begin
                        w_next    = ST_SC_REQ;
                        w_accept  = 1'b1;
                        stall_req = 1'b1;
                    end else begin
                        // Lost reservation: fail without touching the bus
                        result_valid = 1'b1;
                        llbit_we_o   = WriteEnable;
                        w_link_clr   = 1'b1;
                    end
                end
            end
            ST_LL_REQ, ST_SC_REQ: begin
                bus_req   = 1'b1;
                stall_req = 1'b1;
                if (bus_ack) begin
                    if (flush) begin
                        w_next = ST_IDLE;
                    end else begin
                        w_next    = ST_DONE;
                        w_capture = 1'b1;
                        if (r_state == ST_LL_REQ) w_link_set = 1'b1;
                        else                      w_link_clr = 1'b1;
                    end
                end else if (flush) begin
                    w_next = ST_ABORT;
                end
            end
            ST_DONE: begin
                w_next = ST_IDLE;
                if (!flush) begin
                    result_valid = 1'b1;
                    result_data  = r_result;
                    llbit_we_o   = WriteEnable;
                    llbit_o      = r_done_llbit;
                end
            end
            ST_ABORT: begin
                bus_req   = 1'b1;
                stall_req = op_valid;
                if (bus_ack) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
        if (w_snoop_link && !flush) begin
            llbit_we_o = WriteEnable;
            llbit_o    = 1'b0;
        end
        if (rst == RstEnable) begin
            bus_req      = 1'b0;
            stall_req    = 1'b0;
            result_valid = 1'b0;
            result_data  = '0;
            llbit_we_o   = 1'b0;
            llbit_o      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RstEnable) begin
            r_addr       <= '0;
            r_wdata      <= '0;
            r_is_sc      <= 1'b0;
            r_result     <= '0;
            r_done_llbit <= 1'b0;
        end else begin
            if (w_accept) begin
                r_addr  <= op_addr[ADDR_W-1:2];
                r_wdata <= op_wdata;
                r_is_sc <= op_is_sc;
            end
            if (w_capture) begin
                r_result     <= r_is_sc ? DATA_W'(1) : bus_rdata;
                r_done_llbit <= !r_is_sc && !w_snoop_ack;
            end
        end
    end

    assign bus_we    = bus_req & r_is_sc;
    assign bus_addr  = bus_req ? {r_addr, 2'b00} : '0;
    assign bus_wdata = bus_req ? r_wdata : '0;

endmodule

// File: tb/tb_mem_llsc_unit.sv
// Directed bench for mem_llsc_unit: scoreboard of expected GPR/LLbit
// results checked whenever result_valid is seen.
module tb_mem_llsc_unit;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        op_valid;
    logic        op_is_sc;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        llbit_i;
    logic        wb_llbit_we_i;
    logic        wb_llbit_value_i;
    logic        snoop_we;
    logic [31:0] snoop_addr;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;
    logic        stall_req;
    logic        result_valid;
    logic [31:0] result_data;
    logic        llbit_we_o;
    logic        llbit_o;

    typedef struct {
        logic [31:0] data;
        logic        llb;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    mem_llsc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .op_valid         (op_valid),
        .op_is_sc         (op_is_sc),
        .op_addr          (op_addr),
        .op_wdata         (op_wdata),
        .llbit_i          (llbit_i),
        .wb_llbit_we_i    (wb_llbit_we_i),
        .wb_llbit_value_i (wb_llbit_value_i),
        .snoop_we         (snoop_we),
        .snoop_addr       (snoop_addr),
        .bus_req          (bus_req),
        .bus_we           (bus_we),
        .bus_addr         (bus_addr),
        .bus_wdata        (bus_wdata),
        .bus_ack          (bus_ack),
        .bus_rdata        (bus_rdata),
        .stall_req        (stall_req),
        .result_valid     (result_valid),
        .result_data      (result_data),
        .llbit_we_o       (llbit_we_o),
        .llbit_o          (llbit_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (!rst && result_valid) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result observed %h expected none",
                       result_data);
            end
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                chk("result_data", result_data, mon_e.data);
                chk("result_llbit_we", 32'(llbit_we_o), 32'd1);
                chk("result_llbit", 32'(llbit_o), 32'(mon_e.llb));
            end
        end
    end

    task automatic run_op(input bit sc, input logic [31:0] addr,
                          input logic [31:0] wd, input int dly,
                          input logic [31:0] rd, input bit go,
                          input bit snp, input logic [31:0] ed,
                          input bit el);
        int stalls;
        op_valid = 1'b1;
        op_is_sc = sc;
        op_addr  = addr;
        op_wdata = wd;
        exp_q.push_back('{data: ed, llb: el});
        #1;
        if (!go) begin
            chk("fail_stall", 32'(stall_req), 32'd0);
            chk("fail_bus_req", 32'(bus_req), 32'd0);
            chk("fail_valid", 32'(result_valid), 32'd1);
            tick();
            op_valid = 1'b0;
            return;
        end
        stalls = stall_req ? 1 : 0;
        for (int i = 1; i <= dly; i++) begin
            tick();
            if (i == dly) begin
                bus_ack   = 1'b1;
                bus_rdata = rd;
                if (snp) begin
                    snoop_we   = 1'b1;
                    snoop_addr = addr;
                end
            end
            #1;
            if (stall_req) stalls++;
            chk("bus_req", 32'(bus_req), 32'd1);
            chk("bus_addr", bus_addr, addr & 32'hFFFF_FFFC);
            chk("bus_we", 32'(bus_we), 32'(sc));
            if (sc) chk("bus_wdata", bus_wdata, wd);
        end
        tick();
        bus_ack  = 1'b0;
        snoop_we = 1'b0;
        #1;
        chk("done_stall", 32'(stall_req), 32'd0);
        chk("done_valid", 32'(result_valid), 32'd1);
        chk("stall_cycles", 32'(stalls), 32'(dly + 1));
        tick();
        op_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0;
        op_valid = 1'b1; op_is_sc = 1'b1;
        op_addr = 32'h0; op_wdata = 32'h0;
        llbit_i = 1'b0; wb_llbit_we_i = 1'b0; wb_llbit_value_i = 1'b0;
        snoop_we = 1'b0; snoop_addr = 32'h0;
        bus_ack = 1'b0; bus_rdata = 32'h0;
        tick();
        tick();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_stall", 32'(stall_req), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_llbit_we", 32'(llbit_we_o), 32'd0);
        chk("rst_data", result_data, 32'd0);
        rst = 1'b0;
        op_valid = 1'b0;
        tick();

        // LL with a 3-cycle ack
        run_op(1'b0, 32'h1000, 32'h0, 3, 32'hDEADBEEF, 1'b1, 1'b0,
               32'hDEADBEEF, 1'b1);
        // SC that succeeds
        llbit_i = 1'b1;
        run_op(1'b1, 32'h1000, 32'h55, 2, 32'h0, 1'b1, 1'b0, 32'd1, 1'b0);

        // SC to another word fails at once
        run_op(1'b0, 32'h1000, 32'h0, 1, 32'h11, 1'b1, 1'b0, 32'h11, 1'b1);
        run_op(1'b1, 32'h2000, 32'h66, 1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);
        // SC with LLbit cleared fails
        run_op(1'b0, 32'h1000, 32'h0, 1, 32'h22, 1'b1, 1'b0, 32'h22, 1'b1);
        llbit_i = 1'b0;
        run_op(1'b1, 32'h1000, 32'h77, 1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Snoop to the linked word kills the reservation
        llbit_i = 1'b1;
        run_op(1'b0, 32'h1000, 32'h0, 2, 32'h33, 1'b1, 1'b0, 32'h33, 1'b1);
        snoop_we   = 1'b1;
        snoop_addr = 32'h1002;
        #1;
        chk("snoop_we_pulse", 32'(llbit_we_o), 32'd1);
        chk("snoop_llbit", 32'(llbit_o), 32'd0);
        chk("snoop_no_result", 32'(result_valid), 32'd0);
        tick();
        snoop_we = 1'b0;
        run_op(1'b1, 32'h1000, 32'h88, 1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);

        // Snoop coinciding with the LL ack
        run_op(1'b0, 32'h1000, 32'h0, 2, 32'h44, 1'b1, 1'b1, 32'h44, 1'b0);
        run_op(1'b1, 32'h1000, 32'h99, 1, 32'h0, 1'b0, 1'b0, 32'd0, 1'b0);

        // WB bypass rescues an SC while the register still reads 0
        run_op(1'b0, 32'h3000, 32'h0, 1, 32'h55, 1'b1, 1'b0, 32'h55, 1'b1);
        llbit_i          = 1'b0;
        wb_llbit_we_i    = 1'b1;
        wb_llbit_value_i = 1'b1;
        run_op(1'b1, 32'h3000, 32'hA5, 1, 32'h0, 1'b1, 1'b0, 32'd1, 1'b0);
        wb_llbit_we_i    = 1'b0;
        wb_llbit_value_i = 1'b0;

        // Flush one cycle after LL accept, ack 4 cycles later
        op_valid = 1'b1;
        op_is_sc = 1'b0;
        op_addr  = 32'h4000;
        #1;
        chk("flush_accept_stall", 32'(stall_req), 32'd1);
        tick();
        flush = 1'b1;
        #1;
        chk("flush_bus_req", 32'(bus_req), 32'd1);
        chk("flush_llbit_we", 32'(llbit_we_o), 32'd0);
        chk("flush_valid", 32'(result_valid), 32'd0);
        tick();
        flush   = 1'b0;
        op_addr = 32'h5000;
        for (int i = 2; i <= 5; i++) begin
            if (i == 5) begin
                bus_ack   = 1'b1;
                bus_rdata = 32'hBAD0BAD0;
            end
            #1;
            chk("abort_bus_req", 32'(bus_req), 32'd1);
            chk("abort_bus_addr", bus_addr, 32'h4000);
            chk("abort_stall", 32'(stall_req), 32'd1);
            chk("abort_llbit_we", 32'(llbit_we_o), 32'd0);
            chk("abort_valid", 32'(result_valid), 32'd0);
            tick();
            bus_ack = 1'b0;
        end
        run_op(1'b0, 32'h5000, 32'h0, 1, 32'h66, 1'b1, 1'b0, 32'h66, 1'b1);
        tick();
        chk("idle_bus_req", 32'(bus_req), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_llsc_unit.md
# mem_llsc_unit

MEM-stage atomic-access unit for LL/SC. It is the consumer and producer on the pipeline side of the LLbit register. It performs the LL load and the SC store over the data bus with a req/ack handshake, and reads LLbit with a bypass from the WB stage. It tracks the linked word address, fails SC without touching the bus when the reservation is lost, and drives the LLbit write port (`llbit_we_o`/`llbit_o`) travelling down to WB.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous reset, active-high
- `flush`  in  1  exception flush; aborts the current operation and drops the reservation
- `op_valid`  in  1  MEM stage holds an LL or SC; held stable while `stall_req`=1
- `op_is_sc`  in  1  0 = LL, 1 = SC
- `op_addr`  in  ADDR_W  effective address; word-aligned (alignment fault raised upstream)
- `op_wdata`  in  DATA_W  SC store data
- `llbit_i`  in  1  current LLbit register value
- `wb_llbit_we_i`  in  1  WB-stage LLbit write enable (bypass)
- `wb_llbit_value_i`  in  1  WB-stage LLbit write value (bypass)
- `snoop_we`  in  1  store by another master observed
- `snoop_addr`  in  ADDR_W  address of that store
- `bus_req`  out  1  data bus request
- `bus_we`  out  1  1 = write (SC), 0 = read (LL)
- `bus_addr`  out  ADDR_W  word address, bits [1:0] forced to 0
- `bus_wdata`  out  DATA_W  store data
- `bus_ack`  in  1  bus completion, single-cycle pulse
- `bus_rdata`  in  DATA_W  read data, valid with `bus_ack`
- `stall_req`  out  1  freeze the pipeline
- `result_valid`  out  1  `result_data` is valid for the GPR write
- `result_data`  out  DATA_W  LL: loaded word; SC: 1 on success, 0 on failure
- `llbit_we_o`  out  1  LLbit write enable toward WB
- `llbit_o`  out  1  LLbit write value

## Operation
- **States:** IDLE, LL_REQ, SC_REQ, DONE, ABORT.
- **Effective LLbit:** `eff_llbit` = `wb_llbit_we_i` ? `wb_llbit_value_i` : `llbit_i`.
- **IDLE, `op_valid` & !`flush`:**
  - LL → LL_REQ.
  - SC with `eff_llbit`=1 & `link_valid` & `op_addr[31:2]`==`link_addr[31:2]` → SC_REQ.
  - Any other SC fails in the same cycle, combinationally: `result_valid`=1, `result_data`=0, `llbit_we_o`=1, `llbit_o`=0, `stall_req`=0, no bus access, `link_valid` cleared.
- **LL_REQ / SC_REQ:** `bus_req`=1, with `bus_addr`/`bus_wdata`/`bus_we` driven from a registered copy of the operation. `stall_req`=1.
- **On `bus_ack`:**
  - Register the result and go to DONE.
  - LL: capture `link_addr`, set `link_valid`.
  - SC: clear `link_valid`.
- **DONE (one cycle):**
  - `result_valid`=1, `stall_req`=0, `llbit_we_o`=1.
  - `llbit_o`=1 after LL, 0 after SC.
  - `result_data` = the loaded word, or 1 for SC.
  - `op_valid` is ignored; it is the same instruction. Next state is IDLE.
- **Snoop:**
  - `snoop_we` & `link_valid` & address match on [31:2] clears `link_valid` and pulses `llbit_we_o`=1, `llbit_o`=0.
  - If this coincides with an LL `bus_ack` to the same word, the snoop wins: the link is not set and DONE writes `llbit_o`=0. The LL data is still returned.
- **Flush:**
  - In IDLE or DONE: cancel. No `result_valid`, no LLbit write. `link_valid` cleared.
  - In *_REQ without `bus_ack`: go to ABORT. `bus_req` stays high until `bus_ack`, and that ack is discarded.
  - In *_REQ with `bus_ack` in the same cycle: discard the result and go to IDLE.
  - The LLbit register clears itself on flush; this unit issues no write.
- **ABORT:** `bus_req`=1. `stall_req`=`op_valid`. On `bus_ack` → IDLE. A new operation is never accepted in ABORT.
- **Reset:**
  - All outputs 0, state IDLE, `link_valid`=0, `link_addr`=0.
  - Reset mid-transaction drops `bus_req` immediately. Bus-side abort is the bus's responsibility.

## Timing
- **LL, or SC that proceeds:**
  - Accept in cycle 0. `bus_req` rises in cycle 1.
  - With `bus_ack` in cycle k≥1, `stall_req` is high in cycles 0..k and `result_valid` is high in cycle k+1.
  - Minimum latency is 2 cycles.
- **Failing SC:** 0 extra cycles; the result is valid in the accept cycle.
- **Bus:** `bus_req` and the address/data/`we` outputs are stable from assertion until `bus_ack`. Exactly one ack per request.
- **Throughput:** back-to-back operations are possible every k+2 cycles.

## Structure
- **Shared defines file:**
  - state encodings
  - LL/SC op codes
  - `RstEnable`/`WriteEnable` (existing)
- **Sub-module `llsc_link_reg`:**
  - holds `link_valid`/`link_addr`
  - inputs: set, clear, snoop match, flush
  - priority: reset > flush > snoop > clear > set
- The FSM, bypass mux and bus drive live in the top level.

## Test plan
- LL to 0x1000, ack after 3 cycles, `bus_rdata`=0xDEADBEEF → `stall_req` high for 4 cycles, then `result_valid`, `result_data`=0xDEADBEEF, `llbit_we_o`=1, `llbit_o`=1.
- LL 0x1000, then SC 0x1000 with `op_wdata`=0x55 and `llbit_i`=1 → bus write of 0x55 to 0x1000, `result_data`=1, `llbit_o`=0.
- SC 0x2000 after LL 0x1000, and separately SC with `llbit_i`=0 → no `bus_req`, same-cycle `result_data`=0, `stall_req`=0.
- LL 0x1000, then `snoop_we` to 0x1002 → `llbit_we_o` pulse with value 0; a following SC 0x1000 fails. Repeat with the snoop coinciding with the LL ack → DONE writes `llbit_o`=0.
- SC issued while `llbit_i`=0 but `wb_llbit_we_i`=1, `wb_llbit_value_i`=1, link valid → bypass lets the SC go to the bus.
- `flush` one cycle after LL accept, ack 4 cycles later → `bus_req` held until ack, no `result_valid`, no LLbit write, and a new LL offered during ABORT stalls until IDLE.
